// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential multiply/divide unit that owns the HI/LO pair.
// Produces one bit per cycle over WIDTH cycles, then one fix-up cycle that
// applies the sign correction and commits the result to hi/lo.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Architectural and working state
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     operand_q, operand_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;

    // Request decode and operand conditioning
    logic                 accept;
    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    // Per-iteration datapath values
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH-1:0]     rem_diff;
    logic                 rem_fits;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quot_raw, rem_raw;
    logic [WIDTH-1:0]     quot_fixed, rem_fixed;

    // Shared combinational datapath: operand magnitudes, one multiply step,
    // one restoring-divide step, and the final sign-corrected results.
    always_comb begin
        accept    = req_valid && ready_q;
        signed_op = (Funct == FN_MULT) || (Funct == FN_DIV);
        a_neg     = signed_op && Rdata1[WIDTH-1];
        b_neg     = signed_op && Rdata2[WIDTH-1];
        a_mag     = a_neg ? (~Rdata1 + 1'b1) : Rdata1;
        b_mag     = b_neg ? (~Rdata2 + 1'b1) : Rdata2;

        // Shift-add: acc holds {partial product, remaining multiplier bits}
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, operand_q} : {(WIDTH+1){1'b0}});

        // Restoring divide: acc holds {partial remainder, dividend/quotient}
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_fits  = rem_shift >= {1'b0, operand_q};
        rem_diff  = rem_shift[WIDTH-1:0] - operand_q;

        prod_fixed = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quot_raw   = acc_q[WIDTH-1:0];
        rem_raw    = acc_q[2*WIDTH-1:WIDTH];
        quot_fixed = neg_res_q ? (~quot_raw + 1'b1) : quot_raw;
        rem_fixed  = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
    end

    // Next-state logic for the IDLE/CALC/FIX sequence and the HI/LO pair
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        operand_d  = operand_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        ready_d    = ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (Funct)
                        FN_MTHI: hi_d = Rdata2;
                        FN_MTLO: lo_d = Rdata2;
                        FN_MULT, FN_MULTU: begin
                            state_d    = CALC;
                            ready_d    = 1'b0;
                            cnt_d      = '0;
                            is_div_d   = 1'b0;
                            acc_d      = {{WIDTH{1'b0}}, b_mag};
                            operand_d  = a_mag;
                            neg_res_d  = a_neg ^ b_neg;
                            neg_rem_d  = 1'b0;
                            div_zero_d = 1'b0;
                        end
                        FN_DIV, FN_DIVU: begin
                            state_d    = CALC;
                            ready_d    = 1'b0;
                            cnt_d      = '0;
                            is_div_d   = 1'b1;
                            acc_d      = {{WIDTH{1'b0}}, a_mag};
                            operand_d  = b_mag;
                            neg_res_d  = a_neg ^ b_neg;
                            neg_rem_d  = a_neg;
                            div_zero_d = (Rdata2 == '0);
                        end
                        default: ;
                    endcase
                end
            end

            CALC: begin
                if (is_div_q) begin
                    acc_d = {(rem_fits ? rem_diff : rem_shift[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], rem_fits};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (is_div_q) begin
                    lo_d = div_zero_q ? {WIDTH{1'b1}} : quot_fixed;
                    hi_d = rem_fixed;
                end else begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end
                done_d  = 1'b1;
                ready_d = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State register with synchronous active-low reset that aborts any operation
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = ~ready_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit with hand-computed
// expected HI/LO values, latency, handshake and reset-abort behaviour.
module tb_muldiv_unit;

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  Funct = 6'h00;
    logic [31:0] Rdata1 = '0;
    logic [31:0] Rdata2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .Funct     (Funct),
        .Rdata1    (Rdata1),
        .Rdata2    (Rdata2),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running clock, 10 time units per period
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present a request and hold it until it is taken; returns #edges waited
    task automatic applyStimulus(input logic [5:0] fn, input logic [31:0] a,
                                 input logic [31:0] b, output int waits);
        Funct     = fn;
        Rdata1    = a;
        Rdata2    = b;
        req_valid = 1'b1;
        waits     = 0;
        while (!req_ready && waits < 100) begin
            @(posedge CLK); #1;
            waits++;
        end
        if (!req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    // Follow an operation from just after its accept edge until done pulses
    task automatic waitDone(output int edges, output int busyCycles);
        logic [31:0] hiStart;
        logic [31:0] loStart;
        hiStart    = hi;
        loStart    = lo;
        edges      = 0;
        busyCycles = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge CLK); #1;
            edges++;
            if (busy) busyCycles++;
            if (edges == 16) begin
                checkOutput("hold_hi_mid_calc", hi, hiStart);
                checkOutput("hold_lo_mid_calc", lo, loStart);
                checkOutput("ready_low_mid_calc", {31'd0, req_ready}, 32'd0);
            end
        end
        if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int waits;
        int edges;
        int busyCycles;
        int doneSeen;

        // Reset held low for two edges
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Signed multiply -3 * 7 = -21
        applyStimulus(FN_MULT, 32'hFFFF_FFFD, 32'd7, waits);
        waitDone(edges, busyCycles);
        checkOutput("mult_latency", edges, 32'd33);
        checkOutput("mult_busy_cycles", busyCycles, 32'd33);
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFEB);
        checkOutput("mult_ready_with_done", {31'd0, req_ready}, 32'd1);
        @(posedge CLK); #1;
        checkOutput("done_single_pulse", {31'd0, done}, 32'd0);

        // Unsigned max*max, then signed -7/2 accepted on the edge after done
        applyStimulus(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, waits);
        waitDone(edges, busyCycles);
        checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_lo", lo, 32'h0000_0001);
        applyStimulus(FN_DIV, 32'hFFFF_FFF9, 32'd2, waits);
        checkOutput("b2b_accept_waits", waits, 32'd0);
        checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
        waitDone(edges, busyCycles);
        checkOutput("div_latency", edges, 32'd33);
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);

        // Unsigned divide by zero
        applyStimulus(FN_DIVU, 32'd5, 32'd0, waits);
        waitDone(edges, busyCycles);
        checkOutput("divu0_latency", edges, 32'd33);
        checkOutput("divu0_lo", lo, 32'hFFFF_FFFF);
        checkOutput("divu0_hi", hi, 32'd5);

        // Signed divide by zero with a negative dividend
        applyStimulus(FN_DIV, 32'hFFFF_FFF9, 32'd0, waits);
        waitDone(edges, busyCycles);
        checkOutput("div0_lo", lo, 32'hFFFF_FFFF);
        checkOutput("div0_hi", hi, 32'hFFFF_FFF9);

        // Signed overflow case
        applyStimulus(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, waits);
        waitDone(edges, busyCycles);
        checkOutput("divovf_lo", lo, 32'h8000_0000);
        checkOutput("divovf_hi", hi, 32'h0);

        // Signed divide, positive dividend by negative divisor: 17 / -5
        applyStimulus(FN_DIV, 32'd17, 32'hFFFF_FFFB, waits);
        waitDone(edges, busyCycles);
        checkOutput("div_mixed_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_mixed_hi", hi, 32'd2);

        // MTLO completes in one edge without touching hi or pulsing done
        applyStimulus(FN_MTLO, 32'hDEAD_BEEF, 32'hCAFE_0001, waits);
        checkOutput("mtlo_lo", lo, 32'hCAFE_0001);
        checkOutput("mtlo_hi_held", hi, 32'd2);
        checkOutput("mtlo_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("mtlo_done", {31'd0, done}, 32'd0);

        // Unknown function code is accepted with no effect
        applyStimulus(6'h10, 32'h1111_1111, 32'h2222_2222, waits);
        checkOutput("nop_hi", hi, 32'd2);
        checkOutput("nop_lo", lo, 32'hCAFE_0001);
        checkOutput("nop_ready", {31'd0, req_ready}, 32'd1);

        // Clear hi so a premature MTHI write would be visible
        applyStimulus(FN_MTHI, 32'h0, 32'h0, waits);
        checkOutput("mthi_clear", hi, 32'h0);

        // MTHI held while a multiply is in flight: 0x12345 * 0x10000
        applyStimulus(FN_MULT, 32'h0001_2345, 32'h0001_0000, waits);
        Funct     = FN_MTHI;
        Rdata1    = 32'h0;
        Rdata2    = 32'h0000_1234;
        req_valid = 1'b1;
        waitDone(edges, busyCycles);
        checkOutput("held_mult_hi", hi, 32'h0000_0001);
        checkOutput("held_mult_lo", lo, 32'h2345_0000);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        checkOutput("held_mthi_hi", hi, 32'h0000_1234);
        checkOutput("held_mthi_lo", lo, 32'h2345_0000);
        checkOutput("held_mthi_done", {31'd0, done}, 32'd0);

        // Reset asserted at CALC cycle 10 aborts the multiply
        applyStimulus(FN_MULT, 32'd3, 32'd5, waits);
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        checkOutput("abort_hi", hi, 32'h0);
        checkOutput("abort_lo", lo, 32'h0);
        checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (done) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 32'd0);

        // Fresh unsigned divide after the abort: 100 / 7
        applyStimulus(FN_DIVU, 32'd100, 32'd7, waits);
        waitDone(edges, busyCycles);
        checkOutput("divu_lo", lo, 32'd14);
        checkOutput("divu_hi", hi, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the main sequence stalls
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got 0x%08h, expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
